// File: rtl/dpram_reader_pkg.sv
// Shared types for the dual-port RAM stream reader: FSM state encoding and skid buffer depth.
package dpram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_fifo2.sv
// Two-entry FIFO that catches RAM read data and presents it on a valid/ready stream.
// Head data stays stable until popped; flush empties it without touching stored words.
module stream_skid_fifo2 #(
    parameter int dWidth = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [dWidth-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [dWidth-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [dWidth-1:0] r_mem0;
    logic [dWidth-1:0] r_mem1;
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem0   <= '0;
            r_mem1   <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                if (r_wr_ptr) r_mem1 <= i_data;
                else          r_mem0 <= i_data;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_rd_ptr ? r_mem1 : r_mem0;
    assign o_count = r_count;

endmodule

// File: rtl/dpram_stream_reader.sv
// Sweeps a window of a dual-port RAM read port and streams the words out on valid/ready.
// Stream handshake: a word moves on a clock edge where out_valid && out_ready; while out_valid is
// high and out_ready low, out_valid/out_data/out_last hold their values.
module dpram_stream_reader
    import dpram_reader_pkg::*;
#(
    parameter int aWidth = 10,
    parameter int dWidth = 8,
    parameter int lWidth = aWidth + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [aWidth-1:0] start_addr,
    input  logic [lWidth-1:0] length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [aWidth-1:0] ram_addr,
    output logic              ram_we,
    input  logic [dWidth-1:0] ram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [dWidth-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        dbg_state
);

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic [aWidth-1:0] r_addr;
    logic [lWidth-1:0] r_len;
    logic [lWidth-1:0] r_issue_cnt;
    logic [lWidth-1:0] r_xfer_cnt;
    logic              r_inflight;
    logic              w_pop;
    logic              w_issue;
    logic              w_start_ok;
    logic              w_abort_ok;
    logic              w_last_issue;
    logic              w_last_xfer;
    logic [1:0]        w_fifo_count;
    logic [2:0]        w_occ;

    // ram_addr only advances once the word sitting on it is guaranteed a FIFO slot when it
    // returns; until then the address is held and the read is simply not committed yet.
    assign w_pop        = out_valid && out_ready;
    assign w_occ        = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_start_ok   = (r_state == IDLE) && start;
    assign w_abort_ok   = abort && ((r_state == RUN) || (r_state == DRAIN));
    assign w_issue      = (r_state == RUN) && !abort && (w_occ < 3'(SKID_DEPTH));
    assign w_last_issue = (r_issue_cnt == r_len - lWidth'(1));
    assign w_last_xfer  = (r_xfer_cnt == r_len - lWidth'(1));

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = (length == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (abort)                        w_next = IDLE;
                else if (w_issue && w_last_issue) w_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort)                     w_next = IDLE;
                else if (w_pop && w_last_xfer) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_xfer_cnt  <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            if (w_start_ok) begin
                r_addr      <= start_addr;
                r_len       <= length;
                r_issue_cnt <= '0;
                r_xfer_cnt  <= '0;
            end else begin
                if (w_issue) begin
                    r_addr      <= r_addr + aWidth'(1);
                    r_issue_cnt <= r_issue_cnt + lWidth'(1);
                end
                if (w_pop) r_xfer_cnt <= r_xfer_cnt + lWidth'(1);
            end
        end
    end

    stream_skid_fifo2 #(
        .dWidth (dWidth)
    ) u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_flush (w_abort_ok),
        .i_push  (r_inflight),
        .i_data  (ram_q),
        .i_pop   (w_pop),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_count (w_fifo_count)
    );

    assign ram_addr  = r_addr;
    assign ram_we    = 1'b0;
    assign out_last  = out_valid && w_last_xfer;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: RAM model preloaded with mem[i] = i[7:0], scoreboard of
// expected {last, data} words and done-pulse cycles, fed by sweep tasks and drained by a monitor.
module tb_dpram_stream_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  dbg_state;

    logic [7:0]  mem [0:1023];
    logic [8:0]  exp_q [$];
    int          exp_done_q [$];
    int          exp_first_q [$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    logic [9:0]  mon_next_addr = '0;

    logic        prev_stall = 1'b0;
    logic        prev_abort = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;

    dpram_stream_reader #(
        .aWidth (10),
        .dWidth (8),
        .lWidth (11)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_q      (ram_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .dbg_state  (dbg_state)
    );

    // clock / reset / RAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    end
    always @(posedge clk) ram_q <= mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard on every handshake and checks done timing
    always @(negedge clk) begin
        logic [9:0] ahead;
        logic [8:0] exp_word;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !prev_abort)
                chk("stall_hold", {23'd0, out_valid, out_last, out_data}, {23'd0, 1'b1, prev_last, prev_data});
            if (out_valid && exp_first_q.size() > 0)
                chk("first_valid_cycle", cyc, exp_first_q.pop_front());
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %0h, expected no word (cycle %0d)", out_data, cyc);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("stream_word", {23'd0, out_last, out_data}, {23'd0, exp_word});
                end
                hs_cnt++;
                mon_next_addr = mon_next_addr + 10'd1;
            end
            if (busy) begin
                ahead = ram_addr - mon_next_addr;
                n_checks++;
                if (ahead > 10'd2) begin
                    n_errors++;
                    $display("FAIL addr_ahead: ram_addr %0h is %0d past next word %0h, limit 2", ram_addr, ahead, mon_next_addr);
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    int d;
                    d = exp_done_q.pop_front();
                    if (d >= 0) chk("done_cycle", cyc, d);
                end
                done_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_abort = abort;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // driver: one sweep, optionally with random backpressure, an ignored start, or an abort
    task automatic run_sweep(input int addr, input int len, input bit rnd, input bit timed,
                             input int abort_after, input bit inject);
        int  s;
        int  base_hs;
        int  base_done;
        bit  finished;
        bit  aborted;
        for (int i = 0; i < len; i++)
            exp_q.push_back({i == len - 1, 8'((addr + i) % 256)});
        s = cyc;
        if (len == 0) begin
            exp_done_q.push_back(timed ? s + 1 : -1);
        end else begin
            exp_done_q.push_back(timed ? s + len + 3 : -1);
            if (timed) exp_first_q.push_back(s + 3);
        end
        base_hs = hs_cnt;
        base_done = done_cnt;
        mon_next_addr = 10'(addr);
        start = 1'b1;
        start_addr = 10'(addr);
        length = 11'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        finished = 1'b0;
        aborted = 1'b0;
        for (int iter = 0; iter < len * 8 + 40 && !finished; iter++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && iter == 1) begin
                start = 1'b1;
                start_addr = 10'h100;
                length = 11'd3;
            end else begin
                start = 1'b0;
            end
            if (abort_after >= 0 && hs_cnt - base_hs == abort_after) begin
                out_ready = 1'b0;
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                exp_q.delete();
                exp_done_q.delete();
                exp_first_q.delete();
                repeat (3) @(posedge clk);
                #1;
                chk("abort_no_done", done_cnt - base_done, 0);
                aborted = 1'b1;
                finished = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (done_cnt != base_done) finished = 1'b1;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!finished) begin
            n_checks++;
            n_errors++;
            $display("FAIL sweep_timeout: got no done, expected done for addr %0h len %0d", addr, len);
            exp_q.delete();
            exp_done_q.delete();
            exp_first_q.delete();
        end else if (!aborted) begin
            chk("busy_after_done", busy, 0);
            chk("words_left", exp_q.size(), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        length = '0;
        abort = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        run_sweep(10'h010, 4, 1'b0, 1'b1, -1, 1'b0);
        run_sweep(10'h3FE, 4, 1'b0, 1'b1, -1, 1'b0);
        run_sweep(10'h010, 8, 1'b1, 1'b0, -1, 1'b0);
        run_sweep(10'h000, 0, 1'b0, 1'b1, -1, 1'b0);
        run_sweep(10'h040, 6, 1'b0, 1'b1, -1, 1'b1);
        run_sweep(10'h080, 16, 1'b0, 1'b0, 5, 1'b0);
        run_sweep(10'h020, 2, 1'b0, 1'b1, -1, 1'b0);
        for (int k = 0; k < 4; k++)
            run_sweep(int'($urandom_range(0, 1023)), int'($urandom_range(1, 24)), 1'b1, 1'b0, -1, 1'b0);

        for (int i = 0; i < 100; i++)
            exp_q.push_back({i == 99, 8'((16'h300 + i) % 256)});
        exp_done_q.push_back(-1);
        mon_next_addr = 10'h300;
        start = 1'b1;
        start_addr = 10'h300;
        length = 11'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        chk("midrst_out_data", out_data, 0);
        exp_q.delete();
        exp_done_q.delete();
        exp_first_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_sweep(10'h000, 1024, 1'b0, 1'b1, -1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
